// File: rtl/conv_tuser_gen.sv
// conv_tuser_gen
//   Transmit-side sequencer for the conv-engine AXI-Stream input. For each
//   layer it accepts one config handshake, emits one config beat, then passes
//   (cin_1+1)*(cols_1+1)*(blocks_1+1) pixel words through a single registered
//   output stage. Each word is tagged with the TUSER fields used downstream:
//   is_config, is_cin_last, is_cols_1_k2 and kw2.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   cfg_valid/cfg_ready per-layer config handshake
//   cfg_kw2             kernel half-width (kw = 2*kw2+1)
//   cfg_cols_1          columns-1
//   cfg_cin_1           input channels-1
//   cfg_blocks_1        blocks-1
//   s_valid/s_ready     input pixel stream handshake
//   s_data              input pixel word
//   m_valid/m_ready     output stream handshake
//   m_data, m_user      output word and side-band fields
//   m_last              final beat of the layer
module conv_tuser_gen #(
    parameter int DATA_WIDTH     = 64,
    parameter int TUSER_WIDTH    = 8,
    parameter int BITS_KW2       = 2,
    parameter int BITS_COLS      = 10,
    parameter int BITS_CIN       = 10,
    parameter int BITS_BLOCKS    = 8,
    parameter int I_IS_CONFIG    = 0,
    parameter int I_IS_CIN_LAST  = 1,
    parameter int I_IS_COLS_1_K2 = 2,
    parameter int I_KW2          = 3
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [BITS_KW2-1:0]    cfg_kw2,
    input  logic [BITS_COLS-1:0]   cfg_cols_1,
    input  logic [BITS_CIN-1:0]    cfg_cin_1,
    input  logic [BITS_BLOCKS-1:0] cfg_blocks_1,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_WIDTH-1:0]  s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic [TUSER_WIDTH-1:0] m_user,
    output logic                   m_last
);

    typedef enum logic [1:0] {IDLE, CONFIG, STREAM} state_t;

    state_t                 state;
    logic [BITS_KW2-1:0]    kw2_q;
    logic [BITS_COLS-1:0]   cols_1_q;
    logic [BITS_CIN-1:0]    cin_1_q;
    logic [BITS_BLOCKS-1:0] blocks_1_q;
    logic [BITS_CIN-1:0]    cin_cnt;
    logic [BITS_COLS-1:0]   col_cnt;
    logic [BITS_BLOCKS-1:0] blk_cnt;
    // Set once the final input beat of the layer has been taken, so the
    // output stage cannot pull an extra word while the m_last beat drains.
    logic                   src_done;

    logic                   s_fire;
    logic                   m_fire;
    logic                   cin_last;
    logic                   col_last;
    logic                   blk_last;
    logic [BITS_COLS:0]     cols_k2_diff;
    logic [TUSER_WIDTH-1:0] user_data;
    logic [TUSER_WIDTH-1:0] user_cfg;

    assign cfg_ready = (state == IDLE);
    assign s_ready   = (state == STREAM) && !src_done && (!m_valid || m_ready);
    assign s_fire    = s_valid && s_ready;
    assign m_fire    = m_valid && m_ready;

    assign cin_last = (cin_cnt == cin_1_q);
    assign col_last = (col_cnt == cols_1_q);
    assign blk_last = (blk_cnt == blocks_1_q);

    // One extra bit so that cols_1 < kw2 shows up as a set MSB (underflow).
    assign cols_k2_diff = {1'b0, cols_1_q} - (BITS_COLS + 1)'(kw2_q);

    always_comb begin
        user_data                          = '0;
        user_data[I_KW2 +: BITS_KW2]       = kw2_q;
        user_data[I_IS_CIN_LAST]           = cin_last;
        user_data[I_IS_COLS_1_K2]          = !cols_k2_diff[BITS_COLS] &&
                                             (col_cnt == cols_k2_diff[BITS_COLS-1:0]);
    end

    always_comb begin
        user_cfg                      = '0;
        user_cfg[I_KW2 +: BITS_KW2]   = cfg_kw2;
        user_cfg[I_IS_CONFIG]         = 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            kw2_q      <= '0;
            cols_1_q   <= '0;
            cin_1_q    <= '0;
            blocks_1_q <= '0;
            cin_cnt    <= '0;
            col_cnt    <= '0;
            blk_cnt    <= '0;
            src_done   <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_user     <= '0;
            m_last     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        kw2_q      <= cfg_kw2;
                        cols_1_q   <= cfg_cols_1;
                        cin_1_q    <= cfg_cin_1;
                        blocks_1_q <= cfg_blocks_1;
                        cin_cnt    <= '0;
                        col_cnt    <= '0;
                        blk_cnt    <= '0;
                        src_done   <= 1'b0;
                        // Config beat is loaded here so it is visible the
                        // cycle after the handshake.
                        m_valid    <= 1'b1;
                        m_data     <= '0;
                        m_user     <= user_cfg;
                        m_last     <= 1'b0;
                        state      <= CONFIG;
                    end
                end
                CONFIG: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (s_fire) begin
                        m_valid <= 1'b1;
                        m_data  <= s_data;
                        m_user  <= user_data;
                        m_last  <= cin_last && col_last && blk_last;
                        if (cin_last) begin
                            cin_cnt <= '0;
                            if (col_last) begin
                                col_cnt <= '0;
                                blk_cnt <= blk_cnt + 1'b1;
                            end else begin
                                col_cnt <= col_cnt + 1'b1;
                            end
                        end else begin
                            cin_cnt <= cin_cnt + 1'b1;
                        end
                        if (cin_last && col_last && blk_last) begin
                            src_done <= 1'b1;
                        end
                    end else if (m_fire) begin
                        m_valid <= 1'b0;
                        if (m_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_tuser_gen.sv
module tb_conv_tuser_gen;

    logic        clk = 1'b0;
    logic        areset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_kw2;
    logic [9:0]  cfg_cols_1;
    logic [9:0]  cfg_cin_1;
    logic [7:0]  cfg_blocks_1;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic [7:0]  m_user;
    logic        m_last;

    conv_tuser_gen #(
        .DATA_WIDTH(64),
        .TUSER_WIDTH(8),
        .BITS_KW2(2),
        .BITS_COLS(10),
        .BITS_CIN(10),
        .BITS_BLOCKS(8)
    ) dut (
        .aclk(clk),
        .areset(areset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_kw2(cfg_kw2),
        .cfg_cols_1(cfg_cols_1),
        .cfg_cin_1(cfg_cin_1),
        .cfg_blocks_1(cfg_blocks_1),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_user(m_user),
        .m_last(m_last)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // m_ready patterns: 0 always, 1 toggle, 2 random, 3 stalled
    int  m_mode = 0;
    bit  tog    = 1'b0;
    always @(posedge clk) begin
        #1;
        tog = ~tog;
        case (m_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = tog;
            2:       m_ready = ($urandom % 4) != 0;
            default: m_ready = 1'b0;
        endcase
    end

    // ---------------- reference model + per-cycle compare ----------------
    typedef struct {
        logic [63:0] d;
        logic [7:0]  u;
        logic        l;
    } beat_t;

    beat_t       q[$];
    logic [7:0]  log_u[$];
    logic        log_l[$];
    int          log_c[$];
    int          cyc = 0;
    int          layers_done = 0;
    int          p_kw2, p_cols, p_cin, p_blk, idx, remaining;
    bit          busy = 0, streaming = 0;
    bit          stall_prev = 0;
    beat_t       held;

    function automatic beat_t model_beat(input int i, input logic [63:0] d);
        beat_t b;
        int ci, co, bl;
        bit cl, ck;
        ci = i % (p_cin + 1);
        co = (i / (p_cin + 1)) % (p_cols + 1);
        bl = i / ((p_cin + 1) * (p_cols + 1));
        cl = (ci == p_cin);
        ck = (p_cols >= p_kw2) && (co == p_cols - p_kw2);
        b.d = d;
        b.u = 8'((p_kw2 << 3) | (int'(ck) << 2) | (int'(cl) << 1));
        b.l = cl && (co == p_cols) && (bl == p_blk);
        return b;
    endfunction

    always @(negedge clk) begin
        beat_t e, b;
        cyc++;
        if (areset) begin
            q.delete();
            busy       = 0;
            streaming  = 0;
            remaining  = 0;
            stall_prev = 0;
        end else begin
            chk(cfg_ready == !busy, "cfg_ready", cfg_ready, !busy);
            chk(s_ready == (streaming && remaining > 0 && (!m_valid || m_ready)),
                "s_ready", s_ready, streaming && remaining > 0 && (!m_valid || m_ready));
            chk(m_valid == (q.size() != 0), "m_valid", m_valid, q.size() != 0);
            if (stall_prev)
                chk(m_valid && m_data == held.d && m_user == held.u && m_last == held.l,
                    "stall_stable", {m_valid, m_last, m_user}, {1'b1, held.l, held.u});
            if (m_valid && m_ready && q.size() != 0) begin
                e = q.pop_front();
                chk(m_data == e.d, "m_data", m_data, e.d);
                chk(m_user == e.u, "m_user", m_user, e.u);
                chk(m_last == e.l, "m_last", m_last, e.l);
                log_u.push_back(m_user);
                log_l.push_back(m_last);
                log_c.push_back(cyc);
                if (e.u[0]) streaming = 1;
                if (e.l) begin
                    busy      = 0;
                    streaming = 0;
                    layers_done++;
                end
            end
            if (cfg_valid && cfg_ready) begin
                p_kw2     = int'(cfg_kw2);
                p_cols    = int'(cfg_cols_1);
                p_cin     = int'(cfg_cin_1);
                p_blk     = int'(cfg_blocks_1);
                idx       = 0;
                remaining = (p_cin + 1) * (p_cols + 1) * (p_blk + 1);
                b.d = '0;
                b.u = 8'((p_kw2 << 3) | 1);
                b.l = 1'b0;
                q.push_back(b);
                busy = 1;
            end
            if (s_valid && s_ready) begin
                q.push_back(model_beat(idx, s_data));
                idx++;
                remaining--;
            end
            stall_prev = m_valid && !m_ready;
            held.d = m_data;
            held.u = m_user;
            held.l = m_last;
        end
    end

    // ---------------- stimulus ----------------
    localparam int BUDGET = 2000;

    task automatic send_cfg(input int k, input int c, input int ci, input int b);
        int n = 0;
        cfg_kw2      = 2'(k);
        cfg_cols_1   = 10'(c);
        cfg_cin_1    = 10'(ci);
        cfg_blocks_1 = 8'(b);
        cfg_valid    = 1'b1;
        while (n < BUDGET) begin
            @(negedge clk);
            if (cfg_ready) break;
            n++;
        end
        if (n >= BUDGET) chk(0, "cfg_timeout", n, BUDGET);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic send_beats(input int nb, input bit rnd);
        int sent = 0;
        int g = 0;
        while (sent < nb && g < BUDGET) begin
            s_valid = rnd ? (($urandom % 3) != 0) : 1'b1;
            s_data  = {$urandom, $urandom};
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            @(posedge clk);
            #1;
            g++;
        end
        s_valid = 1'b0;
        if (g >= BUDGET) chk(0, "s_timeout", sent, nb);
    endtask

    task automatic wait_layers(input int target);
        int g = 0;
        while (layers_done < target && g < BUDGET) begin
            @(posedge clk);
            g++;
        end
        #1;
        if (g >= BUDGET) chk(0, "layer_timeout", layers_done, target);
    endtask

    task automatic do_layer(input int k, input int c, input int ci, input int b,
                            input bit rnd, input bit wait_done);
        int target = layers_done + 1;
        send_cfg(k, c, ci, b);
        send_beats((ci + 1) * (c + 1) * (b + 1), rnd);
        if (wait_done) wait_layers(target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        logic [7:0] exp_u [8];
        exp_u = '{8'h08, 8'h0A, 8'h08, 8'h0A, 8'h0C, 8'h0E, 8'h08, 8'h0A};
        areset = 1'b1; cfg_valid = 1'b0; s_valid = 1'b0; s_data = '0;
        cfg_kw2 = '0; cfg_cols_1 = '0; cfg_cin_1 = '0; cfg_blocks_1 = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk(m_valid == 1'b0 && m_last == 1'b0, "reset_valid_last", {m_valid, m_last}, 0);
        chk(m_data == '0 && m_user == '0, "reset_data_user", m_user, 0);
        chk(cfg_ready == 1'b1 && s_ready == 1'b0, "reset_ready", {cfg_ready, s_ready}, 2'b10);
        areset = 1'b0;

        // basic layer, continuous ready
        m_mode = 0;
        s0 = log_u.size();
        do_layer(1, 3, 1, 0, 0, 1);
        chk(log_u.size() == s0 + 9, "t1_count", log_u.size() - s0, 9);
        if (log_u.size() == s0 + 9) begin
            chk(log_u[s0] == 8'h09, "t1_cfg_user", log_u[s0], 8'h09);
            for (int i = 0; i < 8; i++) begin
                chk(log_u[s0 + 1 + i] == exp_u[i], "t1_user", log_u[s0 + 1 + i], exp_u[i]);
                chk(log_l[s0 + 1 + i] == (i == 7), "t1_last", log_l[s0 + 1 + i], i == 7);
                if (i > 0)
                    chk(log_c[s0 + 1 + i] == log_c[s0 + i] + 1, "t1_no_bubble",
                        log_c[s0 + 1 + i] - log_c[s0 + i], 1);
            end
        end

        // same config, toggling ready
        m_mode = 1;
        do_layer(1, 3, 1, 0, 0, 1);

        // cols_1 < kw2: is_cols_1_k2 never set
        m_mode = 2;
        s0 = log_u.size();
        do_layer(2, 1, 1, 1, 1, 1);
        for (int i = s0; i < log_u.size(); i++)
            chk(log_u[i][2] == 1'b0, "t3_no_cols_k2", log_u[i], 0);

        // degenerate single-beat layer
        m_mode = 0;
        s0 = log_u.size();
        do_layer(0, 0, 0, 0, 0, 1);
        chk(log_u.size() == s0 + 2, "t4_count", log_u.size() - s0, 2);
        if (log_u.size() == s0 + 2) begin
            chk(log_u[s0] == 8'h01, "t4_cfg_user", log_u[s0], 8'h01);
            chk(log_u[s0 + 1] == 8'h06 && log_l[s0 + 1] == 1'b1, "t4_data",
                {log_l[s0 + 1], log_u[s0 + 1]}, 9'h106);
        end
        chk(cfg_ready == 1'b1, "t4_cfg_ready_after_last", cfg_ready, 1);

        // back-to-back layers, second cfg held during first layer's tail
        m_mode = 1;
        s0 = log_u.size();
        do_layer(1, 2, 1, 0, 0, 0);
        do_layer(3, 3, 0, 0, 0, 1);
        for (int i = s0 + 1; i < log_u.size(); i++)
            if (log_u[i][0]) begin
                chk(log_u[i] == 8'h19, "t5_cfg2_user", log_u[i], 8'h19);
                chk(log_l[i - 1] == 1'b1, "t5_cfg2_after_last", log_l[i - 1], 1);
            end

        // reset mid-stream with a held beat
        m_mode = 0;
        send_cfg(1, 3, 1, 0);
        m_mode = 3;
        send_beats(1, 0);
        repeat (3) @(posedge clk);
        #1;
        chk(m_valid == 1'b1, "t6_held_before_reset", m_valid, 1);
        areset = 1'b1;
        @(posedge clk);
        #1 areset = 1'b0;
        chk(m_valid == 1'b0 && cfg_ready == 1'b1 && s_ready == 1'b0, "t6_after_reset",
            {m_valid, cfg_ready, s_ready}, 3'b010);
        m_mode = 0;
        s0 = log_u.size();
        do_layer(1, 3, 1, 0, 0, 1);
        chk(log_u.size() == s0 + 9, "t6_restart_count", log_u.size() - s0, 9);

        // randomized layers
        for (int r = 0; r < 8; r++) begin
            m_mode = int'($urandom_range(0, 2));
            do_layer(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1, 1);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
